// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the ALU 4:1 result mux. Each result is
//   captured together with the op select that produced it and the adder
//   carry-out, and held in a 2-entry skid buffer (head + skid) with a
//   valid/ready handshake. This timing-isolates the mux path from the
//   consumer. When out_ready stays high the stage moves one result per cycle.
//
//   in_ready is a register that depends only on the buffer state, so there is
//   no combinational path from out_ready to in_ready.
//
//   Optional build macro: ALU_FLAGS_EN
//     defined   : out_zero / out_neg are computed from in_result when the
//                 result is captured, and stored with each entry.
//     undefined : out_zero / out_neg are tied low and no flag storage exists.
//   The port list is the same in both builds.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // One buffered entry: the payload copied bit-exact from the mux side.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [SEL_W-1:0] sel;
    logic             cout;
  } entry_t;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;

  logic accept;
  logic pop;

  // Capture handshake qualifiers; in_* are ignored while in_ready is low.
  always_comb begin
    accept          = in_valid & in_ready_q;
    pop             = (state_q != EMPTY) & out_ready;
    in_entry.result = in_result;
    in_entry.sel    = in_sel;
    in_entry.cout   = in_cout;
  end

  // Next-state and data-movement decisions for the head/skid buffer.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = in_entry;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_entry;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // accept cannot occur here: in_ready is low while FULL.
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    in_ready_d = (state_d != FULL);
  end

  // State, ready and payload registers; reset discards both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic head_zero_q, head_zero_d;
  logic head_neg_q,  head_neg_d;
  logic skid_zero_q, skid_zero_d;
  logic skid_neg_q,  skid_neg_d;
  logic in_zero;
  logic in_neg;

  // Flags follow the same movement as the payload they were derived from.
  always_comb begin
    in_zero     = ~|in_result;
    in_neg      = in_result[WIDTH-1];
    head_zero_d = head_zero_q;
    head_neg_d  = head_neg_q;
    skid_zero_d = skid_zero_q;
    skid_neg_d  = skid_neg_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          head_zero_d = in_zero;
          head_neg_d  = in_neg;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_zero_d = in_zero;
          head_neg_d  = in_neg;
        end else if (accept) begin
          skid_zero_d = in_zero;
          skid_neg_d  = in_neg;
        end
      end
      FULL: begin
        if (pop) begin
          head_zero_d = skid_zero_q;
          head_neg_d  = skid_neg_q;
        end
      end
      default: begin
        head_zero_d = 1'b0;
        head_neg_d  = 1'b0;
      end
    endcase
  end

  // Per-entry flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_zero_q <= 1'b0;
      head_neg_q  <= 1'b0;
      skid_zero_q <= 1'b0;
      skid_neg_q  <= 1'b0;
    end else begin
      head_zero_q <= head_zero_d;
      head_neg_q  <= head_neg_d;
      skid_zero_q <= skid_zero_d;
      skid_neg_q  <= skid_neg_d;
    end
  end

  assign out_zero = head_zero_q;
  assign out_neg  = head_neg_q;
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = head_q.result;
  assign out_sel    = head_q.sel;
  assign out_cout   = head_q.cout;

endmodule
